alu_rs: RTL
===========

Name: alu_rs

Overview:
- Single-entry Tomasulo reservation station placed directly upstream of one alu instance; one alu_rs/alu pair per functional unit, both carrying the same TAG.
- Accepts one dispatched ALU op with operands that are either values or pending producer tags.
- Snoops the CDB terms until both operands resolve, then issues to the alu through oper/rs1/rs2/ready.
- Stays busy until the alu's broadcast cycle so TAG remains unique in flight.

Parameters:
- TAG, ALU_1, rs_tag_t identity of this station; equals the paired alu's TAG.
- N_CDB, 2, number of CDB terms snooped (≥1).

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- dispatch_valid_i  in  1  dispatch request; accepted only when busy_o=0.
- dispatch_op_i  in  alu_op_t  operation.
- dispatch_qj_i  in  rs_tag_t  rs1 producer tag; NO_VAL means dispatch_vj_i is valid.
- dispatch_vj_i  in  word32_t  rs1 value (or immediate path already folded in by dispatch).
- dispatch_qk_i  in  rs_tag_t  rs2 producer tag; NO_VAL means dispatch_vk_i is valid.
- dispatch_vk_i  in  word32_t  rs2 value or immediate.
- cdb_i  in  cdb_t[N_CDB]  snooped broadcast terms (tag, val).
- busy_o  out  1  station occupied.
- oper_o  out  alu_op_t  to alu oper_i.
- rs1_val_o  out  word32_t  to alu rs1_val_i.
- rs2_val_o  out  word32_t  to alu rs2_val_i.
- ready_o  out  1  to alu ready_i; issue strobe.

Behaviour:
- Storage: op, qj, vj, qk, vk, and state ∈ {IDLE, WAIT, EXEC}.
- Reset (async, rst_ni=0): state=IDLE, op=ADDR, qj=qk=NO_VAL, vj=vk=0.
  - Outputs during and after reset: busy_o=0, ready_o=0, oper_o=ADDR, rs1_val_o=rs2_val_o=0.
  - Reset mid-WAIT or mid-EXEC abandons the entry; no issue follows.
- Outputs: oper_o/rs1_val_o/rs2_val_o always reflect stored op/vj/vk. busy_o = (state≠IDLE). ready_o = (state==WAIT && qj==NO_VAL && qk==NO_VAL), combinational from registers only.
- IDLE:
  - dispatch_valid_i=1 at an edge: latch the op, qj/vj and qk/vk, then go to WAIT.
  - Dispatch-cycle capture: if dispatch_qx_i≠NO_VAL and it matches cdb_i[n].tag in the same cycle, store qx=NO_VAL and vx=cdb_i[n].val.
- WAIT:
  - Each edge, for each operand with qx≠NO_VAL: if it matches any cdb_i[n].tag, capture that val and set qx=NO_VAL.
  - Wake-up latency: a resolution captured at edge t makes ready_o=1 in cycle t+1, i.e. no combinational CDB→ready path.
  - Both operands may resolve at the same edge, from the same term or from different terms.
  - ready_o=1 at an edge: go to EXEC. The alu samples its inputs at that same edge.
- EXEC:
  - Lasts exactly one cycle; this is the cycle in which the alu drives cdb_term_o.tag=TAG.
  - Next edge: go to IDLE. busy_o=0 from the following cycle, so the minimum dispatch-to-dispatch interval is 3 cycles.
  - ready_o=0 in EXEC.
- dispatch_valid_i while busy_o=1 is ignored; the dispatcher must hold the request. No state change.
- Matching rules:
  - A cdb term with tag NO_VAL never matches.
  - If several terms carry the same tag in one cycle, the lowest index wins. This is illegal upstream; flag it with an assertion.
  - qj or qk equal to TAG is illegal; assert.
- Operand values are passed unmodified, full 32 bits; no arithmetic is done in this block.

Test Plan:
- Ready dispatch: ADDR, qj=qk=NO_VAL, vj=5, vk=7 at t0.
  - Required: ready_o=1 in t1; EXEC in t2 with alu cdb tag=TAG, val=12; busy_o=0 in t3.
- Pending operand: dispatch SUBR, qj=ALU_2, vk=3.
  - t3: cdb_i[1]={ALU_2, 10}. Required: ready_o=0 through t3, ready_o=1 in t4 with rs1_val_o=10; alu broadcasts 7.
- Dispatch-cycle capture: dispatch with qk=ALU_2 while cdb_i[0]={ALU_2, 0xFFFF_FFFF} in the same cycle.
  - Required: ready_o=1 next cycle, rs2_val_o=0xFFFF_FFFF.
- Dual wake-up: qj=ALU_2, qk=ALU_3; both tags appear on cdb_i[0] and cdb_i[1] in the same cycle with vals 4 and 9.
  - Required: ready_o=1 one cycle later, rs1=4, rs2=9.
- Busy ignore: second dispatch held high during WAIT/EXEC.
  - Required: first op unchanged; second accepted at the first edge with busy_o=0; a NO_VAL cdb tag never triggers a capture.
- Async reset in WAIT (qj pending): drop rst_ni mid-cycle.
  - Required: busy_o=0 and ready_o=0 immediately, with no clock edge; a later matching cdb tag produces no issue.

Source files
------------

// File: rtl/alu_rs.sv
// Single-entry reservation station in front of one alu: holds a dispatched op,
// snoops the CDB until both operands resolve, then issues and stays busy through the broadcast.
package alu_rs_pkg;
  typedef enum logic [2:0] {NO_VAL, ALU_1, ALU_2, ALU_3, MUL_1, LSU_1} rs_tag_t;
  typedef enum logic [2:0] {ADDR, SUBR, ANDR, ORR, XORR, SLLR, SRLR, SLTR} alu_op_t;
  typedef logic [31:0] word32_t;
  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
endpackage

module alu_rs
  import alu_rs_pkg::*;
#(
  parameter rs_tag_t     TAG   = ALU_1,
  parameter int unsigned N_CDB = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    dispatch_valid_i,
  input  alu_op_t dispatch_op_i,
  input  rs_tag_t dispatch_qj_i,
  input  word32_t dispatch_vj_i,
  input  rs_tag_t dispatch_qk_i,
  input  word32_t dispatch_vk_i,
  input  cdb_t    cdb_i [N_CDB],
  output logic    busy_o,
  output alu_op_t oper_o,
  output word32_t rs1_val_o,
  output word32_t rs2_val_o,
  output logic    ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC} state_t;

  state_t  r_state, w_state_nxt;
  alu_op_t r_op, w_op_nxt;
  rs_tag_t r_qj, r_qk, w_qj_nxt, w_qk_nxt;
  word32_t r_vj, r_vk, w_vj_nxt, w_vk_nxt;

  rs_tag_t w_qj_src, w_qk_src;
  logic    w_j_hit, w_k_hit;
  word32_t w_j_val, w_k_val;
  logic    w_ready;
  logic    w_dup;

  assign w_ready  = (r_state == S_WAIT) && (r_qj == NO_VAL) && (r_qk == NO_VAL);
  // In IDLE the snoop looks at the incoming dispatch tags so a same-cycle broadcast is not lost.
  assign w_qj_src = (r_state == S_IDLE) ? dispatch_qj_i : r_qj;
  assign w_qk_src = (r_state == S_IDLE) ? dispatch_qk_i : r_qk;

  // CDB snoop; lowest-index term wins, NO_VAL never matches.
  always_comb begin
    w_j_hit = 1'b0;
    w_j_val = '0;
    w_k_hit = 1'b0;
    w_k_val = '0;
    for (int unsigned n = 0; n < N_CDB; n++) begin
      if (!w_j_hit && (w_qj_src != NO_VAL) && (cdb_i[n].tag == w_qj_src)) begin
        w_j_hit = 1'b1;
        w_j_val = cdb_i[n].val;
      end
      if (!w_k_hit && (w_qk_src != NO_VAL) && (cdb_i[n].tag == w_qk_src)) begin
        w_k_hit = 1'b1;
        w_k_val = cdb_i[n].val;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_qj_nxt    = r_qj;
    w_vj_nxt    = r_vj;
    w_qk_nxt    = r_qk;
    w_vk_nxt    = r_vk;
    unique case (r_state)
      S_IDLE: begin
        if (dispatch_valid_i) begin
          w_state_nxt = S_WAIT;
          w_op_nxt    = dispatch_op_i;
          w_qj_nxt    = w_j_hit ? NO_VAL  : dispatch_qj_i;
          w_vj_nxt    = w_j_hit ? w_j_val : dispatch_vj_i;
          w_qk_nxt    = w_k_hit ? NO_VAL  : dispatch_qk_i;
          w_vk_nxt    = w_k_hit ? w_k_val : dispatch_vk_i;
        end
      end
      S_WAIT: begin
        if (w_ready) begin
          w_state_nxt = S_EXEC;
        end else begin
          if (w_j_hit) begin
            w_qj_nxt = NO_VAL;
            w_vj_nxt = w_j_val;
          end
          if (w_k_hit) begin
            w_qk_nxt = NO_VAL;
            w_vk_nxt = w_k_val;
          end
        end
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_op    <= ADDR;
      r_qj    <= NO_VAL;
      r_vj    <= '0;
      r_qk    <= NO_VAL;
      r_vk    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_qj    <= w_qj_nxt;
      r_vj    <= w_vj_nxt;
      r_qk    <= w_qk_nxt;
      r_vk    <= w_vk_nxt;
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign ready_o   = w_ready;
  assign oper_o    = r_op;
  assign rs1_val_o = r_vj;
  assign rs2_val_o = r_vk;

  // Two live CDB terms carrying the same tag means an upstream protocol error.
  always_comb begin
    w_dup = 1'b0;
    for (int unsigned a = 0; a < N_CDB; a++) begin
      for (int unsigned b = a + 1; b < N_CDB; b++) begin
        if ((cdb_i[a].tag != NO_VAL) && (cdb_i[a].tag == cdb_i[b].tag)) w_dup = 1'b1;
      end
    end
  end

  a_no_dup_tag : assert property (@(posedge clk_i) disable iff (!rst_ni) !w_dup);
  a_no_self_dep : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dispatch_valid_i && (r_state == S_IDLE)) |-> ((dispatch_qj_i != TAG) && (dispatch_qk_i != TAG)));

endmodule
